// File: rtl/axil_pkg.sv
// axil_pkg: shared types for the AXI-Lite RAM slice.
// Provides the response code enum and the read-channel FSM state enum.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_ram_array.sv
// axil_ram_array: byte-enabled storage.
// One write port, one read port.
module axil_ram_array #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter     MEM_INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH/8-1:0]  wr_strb,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b])
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/axil_ram.sv
// axil_ram: AXI-Lite slave RAM with independent AW/W capture buffers and a
// read FSM. Ports: clk, rstn (async, active low); AW/W/B write channels;
// AR/R read channels. Macro AXIL_RAM_LATENCY_EN enables READ_LATENCY;
// without it the read latency is fixed at 1 and no wait counter exists.
module axil_ram #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 1024,
    parameter int READ_LATENCY  = 1,
    parameter     MEM_INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [1:0]              rresp
);

    import axil_pkg::*;

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

`ifdef AXIL_RAM_LATENCY_EN
    localparam int LAT = READ_LATENCY;
`else
    localparam int unused_lat = READ_LATENCY;
`endif

    // Any address bit above the array span makes the access out of range.
    function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (OFS + IW)) != '0;
    endfunction

    logic unused_bits;
    assign unused_bits = ^{awaddr[OFS-1:0], araddr[OFS-1:0]};

    // Readies stay low until the first edge after reset release.
    logic rdy;

    logic            aw_full, aw_oor, w_full, commit, wr_en;
    logic [IW-1:0]   aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]   w_strb;
    resp_t           bresp_q;

    assign awready = rdy & ~aw_full & ~bvalid;
    assign wready  = rdy & ~w_full & ~bvalid;
    assign commit  = aw_full & w_full;
    assign wr_en   = commit & ~aw_oor;
    assign bresp   = bresp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy     <= 1'b0;
            aw_full <= 1'b0;
            aw_oor  <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp_q <= OKAY;
        end else begin
            rdy <= 1'b1;
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_idx  <= awaddr[OFS +: IW];
                aw_oor  <= oor(awaddr);
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                bresp_q <= aw_oor ? SLVERR : OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    rd_state_t       state, nstate;
    logic            ar_hs, wait_done, rd_exit, ar_oor;
    logic [IW-1:0]   ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    resp_t           rresp_q;

    assign ar_hs  = arvalid & arready;
    assign rvalid = (state == RD_RESP);
    assign rresp  = rresp_q;

`ifdef AXIL_RAM_LATENCY_EN
    logic [3:0] cnt;

    assign wait_done = (cnt == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (ar_hs) begin
            cnt <= 4'(LAT - 1);
        end else if (state == RD_WAIT && !wait_done) begin
            cnt <= cnt - 4'd1;
        end
    end
`else
    assign wait_done = 1'b1;
`endif

    always_comb begin
        nstate  = state;
        arready = 1'b0;
        rd_exit = 1'b0;
        unique case (state)
            RD_IDLE: begin
                arready = rdy;
                if (arvalid && rdy) nstate = RD_WAIT;
            end
            RD_WAIT: begin
                rd_exit = wait_done;
                if (wait_done) nstate = RD_RESP;
            end
            RD_RESP: begin
                if (rready) nstate = RD_IDLE;
            end
            default: nstate = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= RD_IDLE;
            ar_idx  <= '0;
            ar_oor  <= 1'b0;
            rdata   <= '0;
            rresp_q <= OKAY;
        end else begin
            state <= nstate;
            if (ar_hs) begin
                ar_idx <= araddr[OFS +: IW];
                ar_oor <= oor(araddr);
            end
            if (rd_exit) begin
                rdata   <= ar_oor ? '0 : rd_word;
                rresp_q <= ar_oor ? SLVERR : OKAY;
            end
        end
    end

    axil_ram_array #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (DEPTH),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) u_array (
        .clk     (clk),
        .we      (wr_en),
        .wr_idx  (aw_idx),
        .wr_data (w_data),
        .wr_strb (w_strb),
        .rd_idx  (ar_idx),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_axil_ram.sv
// tb_axil_ram: directed table-driven bench for axil_ram plus hand-written
// sequences for read/write collision and reset during traffic.
module tb_axil_ram;

`ifdef AXIL_RAM_LATENCY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_ram #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .DEPTH         (1024),
        .READ_LATENCY  (4),
        .MEM_INIT_FILE ("")
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready),
        .rresp   (rresp)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Write with W leading AW by 'lead' cycles (0 = same cycle).
    task automatic axw(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int lead,
                       output logic [1:0] resp, output int lat);
        int k;
        bready = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        chk("w_ready", wready, 1);
        if (lead == 0) begin
            awaddr = a; awvalid = 1'b1;
            chk("aw_ready", awready, 1);
        end
        @(negedge clk);
        wvalid = 1'b0;
        if (lead == 0) begin
            awvalid = 1'b0;
        end else begin
            chk("w_full_ready", wready, 0);
            repeat (lead - 1) @(negedge clk);
            awaddr = a; awvalid = 1'b1;
            chk("aw_ready_late", awready, 1);
            @(negedge clk);
            awvalid = 1'b0;
        end
        k = 0;
        while (!bvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done_valid", bvalid, 0);
        chk("b_done_awready", awready, 1);
    endtask

    task automatic axr(input logic [31:0] a, input int hold,
                       output logic [31:0] d, output logic [1:0] resp,
                       output int lat);
        int k;
        logic [31:0] d0;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        k = 0;
        while (!arready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        chk("ar_busy", arready, 0);
        k = 0;
        while (!rvalid && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat = k;
        d = rdata;
        resp = rresp;
        d0 = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_data", rdata, d0);
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_arready", arready, 0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("r_done_valid", rvalid, 0);
        chk("r_done_arready", arready, 1);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        int          hold;
        logic [1:0]  resp;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  rs;
        int          lt;

        vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 2'b00};
        vt[1]  = '{1'b0, 32'h10,       32'hDEADBEEF, 4'h0, 0, 0, 2'b00};
        vt[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 3, 0, 2'b00};
        vt[3]  = '{1'b1, 32'h20,       32'h0000AA00, 4'h2, 3, 0, 2'b00};
        vt[4]  = '{1'b0, 32'h20,       32'h1122AA44, 4'h0, 0, 5, 2'b00};
        vt[5]  = '{1'b1, 32'h1000,     32'hCAFEF00D, 4'hF, 0, 0, 2'b10};
        vt[6]  = '{1'b0, 32'h1000,     32'h00000000, 4'h0, 0, 1, 2'b10};
        vt[7]  = '{1'b0, 32'h0,        32'h00000000, 4'h0, 0, 0, 2'b00};
        vt[8]  = '{1'b0, 32'h13,       32'hDEADBEEF, 4'h0, 0, 0, 2'b00};
        vt[9]  = '{1'b1, 32'hFFC,      32'h12345678, 4'h5, 1, 0, 2'b00};
        vt[10] = '{1'b0, 32'hFFF,      32'h00340078, 4'h0, 0, 2, 2'b00};
        vt[11] = '{1'b0, 32'h80001000, 32'h00000000, 4'h0, 0, 0, 2'b10};
        vt[12] = '{1'b1, 32'h40,       32'h00000011, 4'hF, 0, 0, 2'b00};

        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
        wvalid = 1'b0; bready = 1'b0; araddr = '0; arvalid = 1'b0;
        rready = 1'b0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].wr) begin
                axw(vt[i].addr, vt[i].data, vt[i].strb, vt[i].lead, rs, lt);
                chk($sformatf("v%0d_bresp", i), rs, vt[i].resp);
                chk($sformatf("v%0d_blat", i), lt, 1);
            end else begin
                axr(vt[i].addr, vt[i].hold, d, rs, lt);
                chk($sformatf("v%0d_rdata", i), d, vt[i].data);
                chk($sformatf("v%0d_rresp", i), rs, vt[i].resp);
                chk($sformatf("v%0d_rlat", i), lt, LAT);
            end
        end

        // Write of 0x55 commits on the edge the read samples word 0x40.
        bready = 1'b1;
        for (int c = 0; c < LAT; c++) begin
            if (c == 0) begin
                araddr = 32'h40; arvalid = 1'b1;
                chk("col_arready", arready, 1);
            end
            if (c == LAT - 1) begin
                awaddr = 32'h40; awvalid = 1'b1;
                wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
                chk("col_awready", awready, 1);
                chk("col_wready", wready, 1);
            end
            @(negedge clk);
            if (c == 0) arvalid = 1'b0;
            if (c == LAT - 1) begin
                awvalid = 1'b0; wvalid = 1'b0;
            end
        end
        lt = 0;
        while (!rvalid && lt < 40) begin
            @(negedge clk);
            lt++;
        end
        chk("col_old_data", rdata, 32'h11);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        bready = 1'b0;
        axr(32'h40, 0, d, rs, lt);
        chk("col_new_data", d, 32'h55);

        // Reset while bvalid is held and a read sits in RD_WAIT.
        awaddr = 32'h80; awvalid = 1'b1;
        wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("mr_bvalid_held", bvalid, 1);
        araddr = 32'h80; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("mr_in_wait", rvalid, 0);
        awaddr = 32'h84; awvalid = 1'b1;
        wdata = 32'h99; wvalid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("mr_bvalid", bvalid, 0);
        chk("mr_rvalid", rvalid, 0);
        chk("mr_awready", awready, 0);
        chk("mr_wready", wready, 0);
        chk("mr_arready", arready, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("mr_rel_awready", awready, 1);
        chk("mr_rel_wready", wready, 1);
        chk("mr_rel_arready", arready, 1);
        chk("mr_rel_bvalid", bvalid, 0);
        chk("mr_rel_rvalid", rvalid, 0);
        axr(32'h84, 0, d, rs, lt);
        chk("mr_no_write", d, 32'h0);
        axr(32'h80, 0, d, rs, lt);
        chk("mr_prior_write", d, 32'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
